// File: rtl/bp_nbf_pkg.sv
// Shared NBF definitions for the stream packer and the downstream loader.
`ifndef BP_NBF_PKG_SV
`define BP_NBF_PKG_SV

// Ceiling division used to size flit counts from record and word widths.
`define BP_NBF_CDIV(x, y) (((x) + (y) - 1) / (y))

package bp_nbf_pkg;

  localparam int nbf_opcode_width_gp = 8;
  localparam int nbf_addr_width_gp   = 40;
  localparam int nbf_data_width_gp   = 64;

  // One NBF record; data occupies the low bits, opcode the high bits.
  typedef struct packed {
    logic [nbf_opcode_width_gp-1:0] opcode;
    logic [nbf_addr_width_gp-1:0]   addr;
    logic [nbf_data_width_gp-1:0]   data;
  } bp_nbf_s;

  typedef enum logic [nbf_opcode_width_gp-1:0] {
    e_nbf_write4 = 8'h02,
    e_nbf_write8 = 8'h03,
    e_nbf_finish = 8'hFF
  } bp_nbf_opcode_e;

  typedef enum logic [0:0] {
    e_run  = 1'b0,
    e_done = 1'b1
  } bp_nbf_packer_state_e;

endpackage

`endif

// File: rtl/bp_stream_nbf_packer_oreg.sv
// One-entry output holding register with a valid bit for the NBF packer.
module bp_stream_nbf_packer_oreg #(
  parameter int width_p = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [width_p-1:0] i_data,
  input  logic               i_pop,
  output logic               o_full,
  output logic [width_p-1:0] o_data
);

  logic               r_full;
  logic [width_p-1:0] r_data;

  // Valid bit: a push in the same cycle as a pop keeps the entry occupied.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
    end else begin
      r_full <= i_push | (r_full & ~i_pop);
    end
  end

  // Word storage, loaded whenever a completed flit is pushed.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/bp_stream_nbf_packer.sv
// Packs the host byte stream into little-endian stream words, counts NBF
// records and stops accepting bytes after the end-of-file record.
module bp_stream_nbf_packer
  import bp_nbf_pkg::*;
#(
  parameter int in_width_p          = 8,
  parameter int stream_data_width_p = 32,
  parameter int nbf_opcode_width_p  = 8,
  parameter int nbf_addr_width_p    = 40,
  parameter int nbf_data_width_p    = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           byte_v_i,
  input  logic [in_width_p-1:0]          byte_i,
  output logic                           byte_ready_o,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  output logic                           done_o,
  output logic [31:0]                    record_count_o
);

  localparam int nbf_width_lp      = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int nbf_num_flits_lp  = `BP_NBF_CDIV(nbf_width_lp, stream_data_width_p);
  localparam int bytes_per_flit_lp = stream_data_width_p / in_width_p;
  localparam int byte_cnt_w_lp     = $clog2(bytes_per_flit_lp);
  localparam int flit_cnt_w_lp     = $clog2(nbf_num_flits_lp);
  // The opcode sits directly above address and data, so its record byte index
  // is (addr + data) / byte width; split into flit and in-flit position.
  localparam int op_byte_lp        = (nbf_addr_width_p + nbf_data_width_p) / in_width_p;
  localparam int op_flit_lp        = op_byte_lp / bytes_per_flit_lp;
  localparam int op_pos_lp         = op_byte_lp % bytes_per_flit_lp;

  bp_nbf_packer_state_e                       r_state;
  logic [byte_cnt_w_lp-1:0]                   r_byte_cnt;
  logic [flit_cnt_w_lp-1:0]                   r_flit_cnt;
  logic [nbf_opcode_width_p-1:0]              r_opcode;
  logic [31:0]                                r_record_count;
  logic [stream_data_width_p-in_width_p-1:0]  r_shift;

  logic                           w_byte_last;
  logic                           w_flit_last;
  logic                           w_op_byte;
  logic                           w_accept;
  logic                           w_byte_ready;
  logic                           w_out_full;
  logic                           w_push;
  logic                           w_pop;
  logic [stream_data_width_p-1:0] w_word;

  assign w_byte_last = (r_byte_cnt == byte_cnt_w_lp'(bytes_per_flit_lp - 1));
  assign w_flit_last = (r_flit_cnt == flit_cnt_w_lp'(nbf_num_flits_lp - 1));
  assign w_op_byte   = (r_flit_cnt == flit_cnt_w_lp'(op_flit_lp)) &
                       (r_byte_cnt == byte_cnt_w_lp'(op_pos_lp));

  // Only the flit-completing byte needs room in the output register; a word
  // leaving downstream in the same cycle frees that room.
  assign w_byte_ready = ~reset_i & (r_state == e_run) &
                        ~(w_byte_last & w_out_full & ~stream_ready_i);
  assign w_accept     = byte_v_i & w_byte_ready;
  assign w_push       = w_accept & w_byte_last;
  assign w_pop        = w_out_full & stream_ready_i;
  assign w_word       = {byte_i, r_shift};

  // Record framing: byte/flit counters, opcode capture, record count, EOF state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= e_run;
      r_byte_cnt     <= '0;
      r_flit_cnt     <= '0;
      r_opcode       <= '0;
      r_record_count <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + 1'b1;
      if (w_op_byte) begin
        r_opcode <= byte_i;
      end
      if (w_byte_last) begin
        r_flit_cnt <= w_flit_last ? '0 : r_flit_cnt + 1'b1;
        if (w_flit_last) begin
          r_record_count <= r_record_count + 32'd1;
          if (r_opcode == e_nbf_finish) begin
            r_state <= e_done;
          end
        end
      end
    end
  end

  // Collect the leading bytes of the current flit at their little-endian slots.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int k = 0; k < bytes_per_flit_lp - 1; k++) begin
        if (r_byte_cnt == byte_cnt_w_lp'(k)) begin
          r_shift[k*in_width_p +: in_width_p] <= byte_i;
        end
      end
    end
  end

  bp_stream_nbf_packer_oreg #(
    .width_p (stream_data_width_p)
  ) u_oreg (
    .i_clk  (clk_i),
    .i_rst  (reset_i),
    .i_push (w_push),
    .i_data (w_word),
    .i_pop  (w_pop),
    .o_full (w_out_full),
    .o_data (stream_data_o)
  );

  assign byte_ready_o   = w_byte_ready;
  assign stream_v_o     = w_out_full;
  assign done_o         = (r_state == e_done) & ~w_out_full;
  assign record_count_o = r_record_count;

endmodule

// File: tb/tb_bp_stream_nbf_packer.sv
// Directed bench for bp_stream_nbf_packer: record table plus corner sequences.
module tb_bp_stream_nbf_packer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        byte_v_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        stream_v_o;
  logic [31:0] stream_data_o;
  logic        stream_ready_i;
  logic        done_o;
  logic [31:0] record_count_o;

  always #5 clk_i = ~clk_i;

  bp_stream_nbf_packer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .byte_v_i       (byte_v_i),
    .byte_i         (byte_i),
    .byte_ready_o   (byte_ready_o),
    .stream_v_o     (stream_v_o),
    .stream_data_o  (stream_data_o),
    .stream_ready_i (stream_ready_i),
    .done_o         (done_o),
    .record_count_o (record_count_o)
  );

  typedef struct packed {
    logic [127:0]     rec;  // raw record, byte k at bits 8k+7:8k
    logic [3:0][31:0] w;    // expected words, w[0] first
  } vec_t;

  vec_t        tbl [4];
  vec_t        eof_v;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q [$];

  // Capture every word handed downstream.
  always @(posedge clk_i) begin
    if (!reset_i && stream_v_o && stream_ready_i) q.push_back(stream_data_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc      = 1'b0;
    byte_v_i = 1'b1;
    byte_i   = b;
    for (int i = 0; i < 64 && !acc; i++) begin
      #1;
      if (byte_ready_o) acc = 1'b1;
      @(negedge clk_i);
    end
    byte_v_i = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_range(input logic [127:0] rec, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(rec[8*k +: 8]);
  endtask

  task automatic check_words(input string tag, input vec_t v, input int base);
    for (int k = 0; k < 4; k++) begin
      if (q.size() > base + k) check($sformatf("%s_w%0d", tag, k), q[base+k], v.w[k]);
      else check($sformatf("%s_w%0d_missing", tag, k), 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    reset_i        = 1'b1;
    byte_v_i       = 1'b0;
    stream_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    q.delete();
  endtask

  initial begin
    tbl[0].rec = 128'h0000_0300_0080_0000_0000_1122_3344_5566_7788 >> 0;
    tbl[0].rec = {16'h0000, 8'h03, 40'h00_8000_0000, 64'h1122_3344_5566_7788};
    tbl[0].w   = {32'h0000_0300, 32'h8000_0000, 32'h1122_3344, 32'h5566_7788};
    tbl[1].rec = {16'h0000, 8'h02, 40'h12_3456_789A, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[1].w   = {32'h0000_0212, 32'h3456_789A, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    // Stray 0xFF everywhere except the opcode byte, which is 0x02.
    tbl[2].rec = {16'hFFFF, 8'h02, 40'hFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2].w   = {32'hFFFF_02FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3].rec = {16'h0000, 8'h03, 40'h00_0000_0001, 64'h0000_0000_0000_0000};
    tbl[3].w   = {32'h0000_0300, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    eof_v.rec  = {16'h0000, 8'hFF, 40'h00_0000_0000, 64'h0000_0000_0000_0000};
    eof_v.w    = {32'h0000_FF00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    reset_i        = 1'b1;
    byte_v_i       = 1'b0;
    byte_i         = 8'h00;
    stream_ready_i = 1'b0;
    @(negedge clk_i);
    #1 check("reset_ready_low", {31'd0, byte_ready_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    q.delete();
    #1;
    check("post_reset_ready", {31'd0, byte_ready_o}, 32'd1);
    check("post_reset_stream_v", {31'd0, stream_v_o}, 32'd0);
    check("post_reset_done", {31'd0, done_o}, 32'd0);
    check("post_reset_count", record_count_o, 32'd0);
    @(negedge clk_i);

    // Table of full records with an always-ready consumer
    stream_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.delete();
      send_range(tbl[i].rec, 0, 15);
      @(negedge clk_i);
      @(negedge clk_i);
      check($sformatf("tbl%0d_nwords", i), q.size(), 32'd4);
      check_words($sformatf("tbl%0d", i), tbl[i], 0);
      check($sformatf("tbl%0d_done", i), {31'd0, done_o}, 32'd0);
      check($sformatf("tbl%0d_count", i), record_count_o, i + 1);
    end

    // Backpressure: the 8th byte stalls while the first word is held
    do_reset();
    send_range(tbl[0].rec, 0, 6);
    byte_v_i = 1'b1;
    byte_i   = tbl[0].rec[63:56];
    #1 check("bp_ready_drop", {31'd0, byte_ready_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    #1;
    check("bp_ready_held", {31'd0, byte_ready_o}, 32'd0);
    check("bp_stream_v", {31'd0, stream_v_o}, 32'd1);
    check("bp_word0_held", stream_data_o, 32'h5566_7788);
    check("bp_nothing_sent", q.size(), 32'd0);
    stream_ready_i = 1'b1;
    send_byte(tbl[0].rec[63:56]);
    check("bp_swap_v", {31'd0, stream_v_o}, 32'd1);
    check("bp_swap_word", stream_data_o, 32'h1122_3344);
    send_range(tbl[0].rec, 8, 15);
    @(negedge clk_i);
    @(negedge clk_i);
    check("bp_nwords", q.size(), 32'd4);
    check_words("bp", tbl[0], 0);
    check("bp_count", record_count_o, 32'd1);

    // EOF: data record then 0xFF record; hold the last word before releasing
    do_reset();
    stream_ready_i = 1'b1;
    send_range(tbl[0].rec, 0, 15);
    send_range(eof_v.rec, 0, 15);
    stream_ready_i = 1'b0;
    #1;
    check("eof_last_word_v", {31'd0, stream_v_o}, 32'd1);
    check("eof_last_word", stream_data_o, 32'h0000_FF00);
    check("eof_done_while_held", {31'd0, done_o}, 32'd0);
    check("eof_ready_low", {31'd0, byte_ready_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    check("eof_done_still_held", {31'd0, done_o}, 32'd0);
    stream_ready_i = 1'b1;
    @(negedge clk_i);
    check("eof_done_rise", {31'd0, done_o}, 32'd1);
    begin
      int taken;
      taken    = 0;
      byte_v_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
        byte_i = 8'(k + 8'hA0);
        #1 if (byte_ready_o) taken++;
        @(negedge clk_i);
      end
      byte_v_i = 1'b0;
      check("eof_bytes_ignored", taken, 32'd0);
    end
    check("eof_nwords", q.size(), 32'd8);
    check_words("eof_rec0", tbl[0], 0);
    check_words("eof_rec1", eof_v, 4);
    check("eof_count", record_count_o, 32'd2);
    check("eof_done_stays", {31'd0, done_o}, 32'd1);

    // Reset mid-record: the partial record never reaches the output
    do_reset();
    send_range(tbl[2].rec, 0, 5);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1 check("mid_reset_stream_v", {31'd0, stream_v_o}, 32'd0);
    stream_ready_i = 1'b1;
    send_range(tbl[1].rec, 0, 15);
    @(negedge clk_i);
    @(negedge clk_i);
    check("mid_reset_nwords", q.size(), 32'd4);
    check_words("mid_reset", tbl[1], 0);
    check("mid_reset_count", record_count_o, 32'd1);

    // Record counter wrap
    force dut.r_record_count = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.r_record_count;
    #1 check("wrap_preload", record_count_o, 32'hFFFF_FFFF);
    @(negedge clk_i);
    send_range(tbl[3].rec, 0, 15);
    @(negedge clk_i);
    check("wrap_count", record_count_o, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
